// File: rtl/jtag_master.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_master
//  Purpose  : Command-driven JTAG master. After reset it walks the TAP into
//             Run-Test/Idle. It then accepts one command at a time: TAP reset,
//             IR scan, DR scan or idle clocks. Each command ends with a
//             response word that holds the captured TDO bits.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          system clock, rising-edge active
//    rst_ni       asynchronous active-low reset
//    cmd_valid_i  command request
//    cmd_ready_o  command accept (high only in READY)
//    cmd_op_i     00 TAP reset, 01 IR scan, 10 DR scan, 11 idle clocks
//    cmd_len_i    scan length / idle count, 0 means 32
//    cmd_data_i   TDI bits, LSB first
//    rsp_valid_o  response available (high only in RESP)
//    rsp_ready_i  response consumed
//    rsp_data_o   captured TDO bits, right-justified
//    tck_o        JTAG clock toward the TAP
//    tms_o        JTAG mode select toward the TAP
//    tdi_o        JTAG data toward the TAP
//    td_i         TDO returned from the TAP
//    busy_o       tck pulses pending or running
// ============================================================================
module jtag_master #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [4:0]  cmd_len_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    input  logic        td_i,
    output logic        busy_o
);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;

    // Terminal count of the divider; 8 bits cover CLK_DIV up to 255.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        READY = 3'd1,
        PRE   = 3'd2,
        SHIFT = 3'd3,
        POST  = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t      state,   state_n, nstate;
    logic [5:0]  idx,     idx_n;      // pulse index inside the current state
    logic [7:0]  div_cnt, div_cnt_n;
    logic        launch,  launch_n;   // pulse at (state, idx) not yet driven
    logic        tck,     tck_n;
    logic        tms,     tms_n;
    logic        tdi,     tdi_n;
    logic [1:0]  op,      op_n;
    logic [5:0]  len,     len_n;      // 1..32
    logic [31:0] data,    data_n;
    logic [31:0] rsp,     rsp_n;

    // Number of tck pulses a state produces for a given op.
    function automatic logic [5:0] pulses_in(input state_t s, input logic [1:0] o,
                                             input logic [5:0] n);
        logic [5:0] r;
        r = 6'd0;
        case (s)
            INIT:  r = 6'd6;
            PRE: begin
                case (o)
                    OP_DR:    r = 6'd3;
                    OP_IR:    r = 6'd4;
                    OP_RESET: r = 6'd5;
                    default:  r = 6'd0;
                endcase
            end
            SHIFT: r = (o == OP_RESET) ? 6'd0 : n;
            POST: begin
                case (o)
                    OP_DR, OP_IR: r = 6'd2;
                    OP_RESET:     r = 6'd1;
                    default:      r = 6'd0;
                endcase
            end
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    // TMS level for pulse i of state s.
    function automatic logic tms_at(input state_t s, input logic [1:0] o,
                                    input logic [5:0] n, input logic [5:0] i);
        logic t;
        t = 1'b0;
        case (s)
            INIT: t = (i < 6'd5);
            PRE: begin
                case (o)
                    OP_DR:    t = (i == 6'd0);
                    OP_IR:    t = (i < 6'd2);
                    OP_RESET: t = 1'b1;
                    default:  t = 1'b0;
                endcase
            end
            SHIFT:   t = (o != OP_IDLE) && (i == n - 6'd1);
            POST:    t = (o != OP_RESET) && (i == 6'd0);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // TDI carries data only while shifting a scan.
    function automatic logic tdi_at(input state_t s, input logic [1:0] o,
                                    input logic [31:0] d, input logic [4:0] i);
        return (s == SHIFT) && (o == OP_DR || o == OP_IR) && d[i];
    endfunction

    // State that follows s once its pulses are done; states with no pulses
    // for this op are skipped so they cost no cycles.
    function automatic state_t next_stage(input state_t s, input logic [1:0] o,
                                          input logic [5:0] n);
        state_t r;
        case (s)
            INIT:    r = READY;
            PRE:     r = (pulses_in(SHIFT, o, n) != 6'd0) ? SHIFT : POST;
            SHIFT:   r = (pulses_in(POST, o, n) != 6'd0) ? POST : RESP;
            default: r = RESP;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= INIT;
            idx     <= 6'd0;
            div_cnt <= 8'd0;
            launch  <= 1'b1;
            tck     <= 1'b0;
            tms     <= 1'b1;
            tdi     <= 1'b0;
            op      <= 2'b00;
            len     <= 6'd0;
            data    <= 32'd0;
            rsp     <= 32'd0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            div_cnt <= div_cnt_n;
            launch  <= launch_n;
            tck     <= tck_n;
            tms     <= tms_n;
            tdi     <= tdi_n;
            op      <= op_n;
            len     <= len_n;
            data    <= data_n;
            rsp     <= rsp_n;
        end
    end

    // Pulse timing: a launch edge drives TMS/TDI with tck low, tck rises
    // CLK_DIV edges later (TDO sampled there), and falls CLK_DIV edges after
    // that. The falling edge is also the launch edge of the next pulse.
    // Entry into a sequence (accept or reset) leaves one cycle before the
    // first launch.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        div_cnt_n = div_cnt;
        launch_n  = launch;
        tck_n     = tck;
        tms_n     = tms;
        tdi_n     = tdi;
        op_n      = op;
        len_n     = len;
        data_n    = data;
        rsp_n     = rsp;
        nstate    = state;

        case (state)
            READY: begin
                if (cmd_valid_i) begin
                    op_n      = cmd_op_i;
                    len_n     = (cmd_len_i == 5'd0) ? 6'd32 : {1'b0, cmd_len_i};
                    data_n    = cmd_data_i;
                    rsp_n     = 32'd0;
                    state_n   = (cmd_op_i == OP_IDLE) ? SHIFT : PRE;
                    idx_n     = 6'd0;
                    div_cnt_n = 8'd0;
                    launch_n  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_n = READY;
                end
            end
            default: begin
                if (launch) begin
                    launch_n  = 1'b0;
                    tck_n     = 1'b0;
                    div_cnt_n = 8'd0;
                    tms_n     = tms_at(state, op, len, idx);
                    tdi_n     = tdi_at(state, op, data, idx[4:0]);
                end else if (div_cnt != DIV_LAST) begin
                    div_cnt_n = div_cnt + 8'd1;
                end else begin
                    div_cnt_n = 8'd0;
                    if (!tck) begin
                        tck_n = 1'b1;
                        if (state == SHIFT && (op == OP_DR || op == OP_IR)) begin
                            rsp_n[idx[4:0]] = td_i;
                        end
                    end else begin
                        tck_n = 1'b0;
                        if (idx + 6'd1 != pulses_in(state, op, len)) begin
                            nstate = state;
                            idx_n  = idx + 6'd1;
                        end else begin
                            nstate = next_stage(state, op, len);
                            idx_n  = 6'd0;
                        end
                        state_n = nstate;
                        if (nstate == READY || nstate == RESP) begin
                            // Sequence finished: TMS keeps its last level.
                            tdi_n = 1'b0;
                        end else begin
                            tms_n = tms_at(nstate, op, len, idx_n);
                            tdi_n = tdi_at(nstate, op, data, idx_n[4:0]);
                        end
                    end
                end
            end
        endcase
    end

    assign tck_o       = tck;
    assign tms_o       = tms;
    assign tdi_o       = tdi;
    assign cmd_ready_o = (state == READY);
    assign rsp_valid_o = (state == RESP);
    assign rsp_data_o  = rsp;
    assign busy_o      = !((state == READY) || (state == RESP));

endmodule
`default_nettype wire

// File: tb/tb_jtag_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtag_master
//  Purpose  : Self-checking bench for jtag_master. A CLK_DIV=2 instance runs
//             a table of commands against a one-bit loopback/BYPASS TAP
//             model. A CLK_DIV=1 instance covers idle-clock latency and the
//             held response.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ni;

    // CLK_DIV = 2 instance
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_data, rsp_data;
    logic        tck, tms, tdi, td, busy;

    // CLK_DIV = 1 instance
    logic        c1_valid, c1_ready, r1_valid, r1_ready;
    logic [1:0]  c1_op;
    logic [4:0]  c1_len;
    logic [31:0] c1_data, r1_data;
    logic        tck1, tms1, tdi1, busy1;
    logic        td1;
    assign td1 = 1'b0;

    jtag_master #(.CLK_DIV(2)) u_dut (
        .clk(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .td_i(td), .busy_o(busy)
    );

    jtag_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_ni(rst_ni),
        .cmd_valid_i(c1_valid), .cmd_ready_o(c1_ready),
        .cmd_op_i(c1_op), .cmd_len_i(c1_len), .cmd_data_i(c1_data),
        .rsp_valid_o(r1_valid), .rsp_ready_i(r1_ready), .rsp_data_o(r1_data),
        .tck_o(tck1), .tms_o(tms1), .tdi_o(tdi1), .td_i(td1), .busy_o(busy1)
    );

    // TAP model: a single register loaded from TDI on each tck rise and
    // presented on TDO (loopback delayed one bit, same as BYPASS).
    logic tap_reg = 1'b0;
    assign td = tap_reg;

    int   pulses = 0;
    logic tms_hist [0:4095];
    logic tdi_hist [0:4095];
    always @(posedge tck) begin
        if (pulses < 4096) begin
            tms_hist[pulses] = tms;
            tdi_hist[pulses] = tdi;
        end
        pulses  = pulses + 1;
        tap_reg <= tdi;
    end

    int pulses1 = 0;
    int tms1_ones = 0;
    always @(posedge tck1) begin
        pulses1 = pulses1 + 1;
        if (tms1) tms1_ones = tms1_ones + 1;
    end

    int accepts = 0;
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) accepts = accepts + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  len;
        logic [31:0] data;
        int          npulse;
        logic [63:0] tms_pat;   // bit k = TMS on pulse k
        logic [63:0] tdi_pat;   // bit k = TDI on pulse k
        logic [31:0] rsp;
        int          lat;       // cycles from accept edge to rsp_valid
    } vec_t;

    vec_t vecs [8];

    // Issue one command on the CLK_DIV=2 instance and collect what it did.
    task automatic run_cmd(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data,
                           output int np, output logic [63:0] tms_pat,
                           output logic [63:0] tdi_pat, output logic [31:0] rsp,
                           output int lat);
        int cyc;
        int start;
        cyc = 0;
        @(negedge clk);
        while (!cmd_ready && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        start     = pulses;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        np      = pulses - start;
        tms_pat = '0;
        tdi_pat = '0;
        for (int k = 0; k < np && k < 64; k++) begin
            tms_pat[k] = tms_hist[start + k];
            tdi_pat[k] = tdi_hist[start + k];
        end
        rsp = rsp_data;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    // Called #1 after the edge on which reset was released.
    task automatic check_init(input string tag);
        int cyc;
        int first_rise;
        int ready_at;
        int start;
        logic [63:0] pat;
        logic rsp_seen;
        start      = pulses;
        first_rise = -1;
        ready_at   = -1;
        rsp_seen   = 1'b0;
        cyc        = 0;
        while (ready_at < 0 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (tck && first_rise < 0) first_rise = cyc;
            if (cmd_ready) ready_at = cyc;
            if (rsp_valid) rsp_seen = 1'b1;
        end
        pat = '0;
        for (int k = 0; k < pulses - start && k < 64; k++) pat[k] = tms_hist[start + k];
        check({tag, "_first_rise"}, first_rise, 3);
        check({tag, "_ready_cycle"}, ready_at, 25);
        check({tag, "_pulses"}, pulses - start, 6);
        check({tag, "_tms"}, pat, 64'h1F);
        check({tag, "_no_rsp"}, rsp_seen, 0);
        check({tag, "_ready_busy"}, {cmd_ready, busy, tms}, 3'b100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int np, lat, cyc, a0, s1, o1;
        logic [63:0] tp, dp;
        logic [31:0] rs;
        logic ok;

        vecs[0] = '{2'b10, 5'd8,  32'h0000_00A5, 13, 64'hC01,          64'h528,          32'h0000_004A, 53};
        vecs[1] = '{2'b01, 5'd0,  32'hDEAD_BEEF, 38, 64'h18_0000_0003, 64'hD_EADB_EEF0,  32'hBD5B_7DDE, 153};
        vecs[2] = '{2'b10, 5'd1,  32'hFFFF_FFFF,  6, 64'h19,           64'h8,            32'h0,         25};
        vecs[3] = '{2'b00, 5'd0,  32'hFFFF_FFFF,  6, 64'h1F,           64'h0,            32'h0,         25};
        vecs[4] = '{2'b01, 5'd3,  32'h0000_0005,  9, 64'hC3,           64'h50,           32'h2,         37};
        vecs[5] = '{2'b10, 5'd31, 32'hFFFF_FFFF, 36, 64'h6_0000_0001,  64'h3_FFFF_FFF8,  32'h7FFF_FFFE, 145};
        vecs[6] = '{2'b11, 5'd0,  32'hFFFF_FFFF, 32, 64'h0,            64'h0,            32'h0,         129};
        vecs[7] = '{2'b11, 5'd5,  32'hAAAA_AAAA,  5, 64'h0,            64'h0,            32'h0,         21};

        rst_ni    = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 5'd0; cmd_data = 32'd0; rsp_ready = 1'b0;
        c1_valid  = 1'b0; c1_op  = 2'b00; c1_len  = 5'd0; c1_data  = 32'd0; r1_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {tck, tms, tdi, cmd_ready, rsp_valid, busy, rsp_data},
              {6'b010001, 32'h0});
        check("reset_outs_div1", {tck1, tms1, tdi1, c1_ready, r1_valid, busy1, r1_data},
              {6'b010001, 32'h0});

        @(posedge clk);
        #1 rst_ni = 1'b1;
        check_init("init");

        // Idle clocks on the CLK_DIV=1 instance, response held for 10 cycles.
        check("d1_ready", c1_ready, 1);
        @(negedge clk);
        c1_op = 2'b11; c1_len = 5'd3; c1_data = 32'hFFFF_FFFF; c1_valid = 1'b1;
        s1 = pulses1;
        o1 = tms1_ones;
        @(posedge clk);
        #1 c1_valid = 1'b0;
        lat = 0;
        while (!r1_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("d1_latency", lat, 7);
        check("d1_pulses", pulses1 - s1, 3);
        check("d1_tms_ones", tms1_ones - o1, 0);
        check("d1_rsp", r1_data, 32'h0);
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (tck1 || !r1_valid || r1_data != 32'h0) ok = 1'b0;
        end
        check("d1_hold", ok, 1);
        @(negedge clk);
        r1_ready = 1'b1;
        @(posedge clk);
        #1 r1_ready = 1'b0;
        check("d1_back_ready", {c1_ready, r1_valid, busy1}, 3'b100);

        // Table of commands on the CLK_DIV=2 instance.
        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].op, vecs[i].len, vecs[i].data, np, tp, dp, rs, lat);
            check($sformatf("v%0d_pulses", i), np, vecs[i].npulse);
            check($sformatf("v%0d_tms", i), tp, vecs[i].tms_pat);
            check($sformatf("v%0d_tdi", i), dp, vecs[i].tdi_pat);
            check($sformatf("v%0d_rsp", i), rs, vecs[i].rsp);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
        end

        // cmd_valid held high across RESP: one accept per command.
        a0 = accepts;
        @(negedge clk);
        cmd_op = 2'b11; cmd_len = 5'd1; cmd_data = 32'd0; cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            while (!rsp_valid && cyc < 200) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            @(negedge clk);
            rsp_ready = 1'b1;
            if (k == 2) cmd_valid = 1'b0;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
        repeat (5) @(posedge clk);
        #1;
        check("b2b_accepts", accepts - a0, 3);
        check("b2b_idle_ready", {cmd_ready, rsp_valid}, 2'b10);

        // Reset asserted while pulse 5 of a DR scan is high.
        @(negedge clk);
        cmd_op = 2'b10; cmd_len = 5'd8; cmd_data = 32'h0000_00A5; cmd_valid = 1'b1;
        a0 = pulses;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cyc = 0;
        while (pulses - a0 < 5 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mid_tck_high", tck, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_pins", {tck, tms, tdi, busy, cmd_ready, rsp_valid, rsp_data},
              {6'b010100, 32'h0});
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_held", {tck, tms, tdi, busy, cmd_ready, rsp_valid}, 6'b010100);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        check_init("reinit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
